// File: rtl/pc_seq_pkg.sv
// rtl/pc_seq_pkg.sv - shared types and default constants for the PC sequencer
//
// Contents:
//   state_t      sequencer state: BOOT, RUN, HALT
//   pc_sel_t     next-PC source: HOLD, SEQ, BRANCH, JUMP, RET
//   DEF_RESET_PC default PC loaded on reset
//   DEF_STEP     default sequential increment (power of two)
package pc_seq_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    HOLD   = 3'd0,
    SEQ    = 3'd1,
    BRANCH = 3'd2,
    JUMP   = 3'd3,
    RET    = 3'd4
  } pc_sel_t;

  localparam int unsigned DEF_RESET_PC = 0;
  localparam int unsigned DEF_STEP     = 2;

endpackage

// File: rtl/pc_ras.sv
// rtl/pc_ras.sv - circular return-address stack
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset (stack empties)
//   push         write push_data on top; when full the oldest entry is overwritten
//   push_data    return address to save
//   pop          remove top entry; ignored when empty
//   pop_data     current top entry (valid only when !empty)
//   full, empty  occupancy flags
// push and pop are never asserted together by the sequencer.
module pc_ras #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic         full,
  output logic         empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] top_q;     // next slot to write
  logic [CW-1:0] count_q;
  logic [PW-1:0] top_inc;
  logic [PW-1:0] top_dec;

  assign top_inc  = (top_q == PW'(DEPTH - 1)) ? '0 : top_q + 1'b1;
  assign top_dec  = (top_q == '0) ? PW'(DEPTH - 1) : top_q - 1'b1;
  assign pop_data = mem[top_dec];
  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      top_q   <= '0;
      count_q <= '0;
    end else if (push) begin
      // Once full, the write slot coincides with the oldest entry.
      top_q <= top_inc;
      if (!full) count_q <= count_q + 1'b1;
    end else if (pop && !empty) begin
      top_q   <= top_dec;
      count_q <= count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[top_q] <= push_data;
  end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program-counter stage feeding the datapath adder and fetch
//
// Optional feature macro: PC_RAS_EN (call/return ports plus return-address stack).
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   seq_pc_i          adder sum, pc_o + step_o
//   pc_o, step_o      adder operands; pc_o is also the fetch address
//   fetch_valid_o     fetch request valid (high in RUN)
//   fetch_ready_i     fetch accepts pc_o this cycle
//   br_taken_i/br_target_i    taken branch and its target
//   jump_i/jump_target_i      unconditional jump and its target
//   halt_i, resume_i  enter / leave HALT (halt wins when both)
//   call_i, ret_i     (PC_RAS_EN) jump is a call / return from RAS
//   flush_o           one-cycle pulse after an accepted redirect
//   misalign_o        sticky: a redirect target had low bits set, or RAS underflow
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int           W         = 16,
  parameter logic [W-1:0] RESET_PC  = W'(DEF_RESET_PC),
  parameter int           STEP      = DEF_STEP,
  parameter int           RAS_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] seq_pc_i,
  output logic [W-1:0] pc_o,
  output logic [W-1:0] step_o,
  output logic         fetch_valid_o,
  input  logic         fetch_ready_i,
  input  logic         br_taken_i,
  input  logic [W-1:0] br_target_i,
  input  logic         jump_i,
  input  logic [W-1:0] jump_target_i,
  input  logic         halt_i,
  input  logic         resume_i,
  output logic         flush_o,
`ifdef PC_RAS_EN
  input  logic         call_i,
  input  logic         ret_i,
`endif
  output logic         misalign_o
);

  localparam logic [W-1:0] ALIGN_MASK = W'(STEP - 1);

  state_t       state_q, state_d;
  pc_sel_t      sel;
  logic [W-1:0] pc_q, pc_d;
  logic [W-1:0] raw_tgt;
  logic [W-1:0] tgt_aligned;
  logic         valid_q, flush_q, misalign_q;
  logic         fire, redirect, misalign_hit, ret_underflow;

`ifdef PC_RAS_EN
  logic [W-1:0] ras_pop_data;
  logic         ras_full, ras_empty, ras_push, ras_pop;

  // ret_i outranks jump_i, so a call that coincides with a return never pushes.
  assign ras_push = (state_q == RUN) && jump_i && call_i && !ret_i;
  assign ras_pop  = (state_q == RUN) && ret_i;

  pc_ras #(
    .W     (W),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (ras_push),
    .push_data (seq_pc_i),
    .pop       (ras_pop),
    .pop_data  (ras_pop_data),
    .full      (ras_full),
    .empty     (ras_empty)
  );

  logic unused_ras_full;
  assign unused_ras_full = ras_full;
`else
  logic unused_ras_cfg;
  assign unused_ras_cfg = ^32'(RAS_DEPTH);
`endif

  assign fire = valid_q && fetch_ready_i;

  always_comb begin
    state_d       = state_q;
    sel           = HOLD;
    raw_tgt       = pc_q;
    ret_underflow = 1'b0;
    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (halt_i) state_d = HALT;
        // Redirects never wait for fetch_ready_i.
`ifdef PC_RAS_EN
        if (ret_i) begin
          sel           = RET;
          raw_tgt       = ras_empty ? RESET_PC : ras_pop_data;
          ret_underflow = ras_empty;
        end else
`endif
        if (jump_i) begin
          sel     = JUMP;
          raw_tgt = jump_target_i;
        end else if (br_taken_i) begin
          sel     = BRANCH;
          raw_tgt = br_target_i;
        end else if (fire) begin
          sel = SEQ;
        end
      end
      HALT: begin
        if (!halt_i && resume_i) state_d = RUN;
      end
      default: state_d = BOOT;
    endcase
  end

  assign tgt_aligned  = raw_tgt & ~ALIGN_MASK;
  assign redirect     = (sel == JUMP) || (sel == BRANCH) || (sel == RET);
  assign misalign_hit = (redirect && ((raw_tgt & ALIGN_MASK) != '0)) || ret_underflow;

  always_comb begin
    case (sel)
      SEQ:                pc_d = seq_pc_i;
      BRANCH, JUMP, RET:  pc_d = tgt_aligned;
      default:            pc_d = pc_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      valid_q    <= 1'b0;
      flush_q    <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      valid_q    <= (state_d == RUN);
      flush_q    <= redirect;
      misalign_q <= misalign_q | misalign_hit;
    end
  end

  assign pc_o          = pc_q;
  assign step_o        = W'(STEP);
  assign fetch_valid_o = valid_q;
  assign flush_o       = flush_q;
  assign misalign_o    = misalign_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed self-checking bench for pc_sequencer
module tb_pc_sequencer;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] seq_pc;
  logic [W-1:0] pc;
  logic [W-1:0] step;
  logic         fetch_valid;
  logic         fetch_ready;
  logic         br_taken;
  logic [W-1:0] br_target;
  logic         jump;
  logic [W-1:0] jump_target;
  logic         halt;
  logic         resume;
  logic         flush;
  logic         misalign;
`ifdef PC_RAS_EN
  logic         call;
  logic         ret;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  // Environment model of the datapath adder.
  assign seq_pc = pc + step;

  pc_sequencer #(
    .W         (W),
    .RESET_PC  (16'h0000),
    .STEP      (2),
    .RAS_DEPTH (4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .seq_pc_i      (seq_pc),
    .pc_o          (pc),
    .step_o        (step),
    .fetch_valid_o (fetch_valid),
    .fetch_ready_i (fetch_ready),
    .br_taken_i    (br_taken),
    .br_target_i   (br_target),
    .jump_i        (jump),
    .jump_target_i (jump_target),
    .halt_i        (halt),
    .resume_i      (resume),
    .flush_o       (flush),
`ifdef PC_RAS_EN
    .call_i        (call),
    .ret_i         (ret),
`endif
    .misalign_o    (misalign)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ctl();
    br_taken    = 1'b0;
    br_target   = '0;
    jump        = 1'b0;
    jump_target = '0;
    halt        = 1'b0;
    resume      = 1'b0;
`ifdef PC_RAS_EN
    call        = 1'b0;
    ret         = 1'b0;
`endif
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_ctl();
    fetch_ready = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    tick();  // BOOT -> RUN
  endtask

  initial begin
    rst_n       = 1'b0;
    fetch_ready = 1'b1;
    clear_ctl();
    tick();
    tick();
    check("rst_pc", 32'(pc), 32'h0000);
    check("rst_valid", 32'(fetch_valid), 32'd0);
    check("rst_flush", 32'(flush), 32'd0);
    check("rst_misalign", 32'(misalign), 32'd0);
    check("step_const", 32'(step), 32'd2);

    // Release: one BOOT cycle with valid low, then sequential fetch.
    rst_n = 1'b1;
    check("boot_valid", 32'(fetch_valid), 32'd0);
    tick();
    check("run_pc0", 32'(pc), 32'h0000);
    check("run_valid", 32'(fetch_valid), 32'd1);
    tick();
    check("run_pc2", 32'(pc), 32'h0002);
    tick();
    check("run_pc4", 32'(pc), 32'h0004);
    for (int i = 0; i < 6; i++) tick();
    check("run_pc10", 32'(pc), 32'h0010);

    // Backpressure: hold without retracting valid.
    fetch_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_pc", 32'(pc), 32'h0010);
      check("stall_valid", 32'(fetch_valid), 32'd1);
    end
    fetch_ready = 1'b1;
    tick();
    check("unstall_pc", 32'(pc), 32'h0012);

    // Jump beats branch.
    br_taken = 1'b1; br_target = 16'h0100;
    jump = 1'b1; jump_target = 16'h0200;
    tick();
    clear_ctl();
    check("jump_pc", 32'(pc), 32'h0200);
    check("jump_flush", 32'(flush), 32'd1);
    tick();
    check("jump_flush_end", 32'(flush), 32'd0);
    check("jump_next", 32'(pc), 32'h0202);
    check("aligned_no_mis", 32'(misalign), 32'd0);

    // Misaligned branch, taken while fetch is not ready.
    fetch_ready = 1'b0;
    br_taken = 1'b1; br_target = 16'h0101;
    tick();
    clear_ctl();
    fetch_ready = 1'b1;
    check("mis_br_pc", 32'(pc), 32'h0100);
    check("mis_br_flag", 32'(misalign), 32'd1);
    check("mis_br_flush", 32'(flush), 32'd1);
    tick();
    check("mis_next_pc", 32'(pc), 32'h0102);
    check("mis_sticky", 32'(misalign), 32'd1);

    // Wrap-around.
    jump = 1'b1; jump_target = 16'hFFFE;
    tick();
    clear_ctl();
    check("wrap_pre", 32'(pc), 32'hFFFE);
    tick();
    check("wrap_pc", 32'(pc), 32'h0000);
    check("wrap_flush", 32'(flush), 32'd0);

    // Halt with simultaneous jump.
    halt = 1'b1; jump = 1'b1; jump_target = 16'h0040;
    tick();
    clear_ctl();
    check("halt_pc", 32'(pc), 32'h0040);
    check("halt_valid", 32'(fetch_valid), 32'd0);
    check("halt_flush", 32'(flush), 32'd1);
    jump = 1'b1; jump_target = 16'h0080;
    tick();
    clear_ctl();
    check("halt_ign_pc", 32'(pc), 32'h0040);
    check("halt_ign_flush", 32'(flush), 32'd0);
    halt = 1'b1; resume = 1'b1;
    tick();
    clear_ctl();
    check("halt_wins", 32'(fetch_valid), 32'd0);
    resume = 1'b1;
    tick();
    clear_ctl();
    check("resume_valid", 32'(fetch_valid), 32'd1);
    check("resume_pc", 32'(pc), 32'h0040);
    tick();
    check("resume_adv", 32'(pc), 32'h0042);

    // Mid-operation asynchronous reset discards a pending jump.
    jump = 1'b1; jump_target = 16'h0300;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_pc", 32'(pc), 32'h0000);
    check("async_valid", 32'(fetch_valid), 32'd0);
    check("async_mis", 32'(misalign), 32'd0);
    tick();
    clear_ctl();
    rst_n = 1'b1;
    tick();
    check("post_rst_pc", 32'(pc), 32'h0000);
    check("post_rst_flush", 32'(flush), 32'd0);

`ifdef PC_RAS_EN
    do_reset();
    jump = 1'b1; jump_target = 16'h0020;
    tick();
    clear_ctl();
    check("ras_at20", 32'(pc), 32'h0020);
    jump = 1'b1; call = 1'b1; jump_target = 16'h0080;
    tick();
    clear_ctl();
    check("ras_call_pc", 32'(pc), 32'h0080);
    tick();
    tick();
    check("ras_at84", 32'(pc), 32'h0084);
    ret = 1'b1;
    tick();
    clear_ctl();
    check("ras_ret_pc", 32'(pc), 32'h0022);
    check("ras_ret_flush", 32'(flush), 32'd1);

    // Five calls into a four-deep stack: oldest return address is lost.
    for (int i = 1; i <= 5; i++) begin
      jump = 1'b1; call = 1'b1; jump_target = 16'(i * 16'h1000);
      tick();
    end
    clear_ctl();
    check("ras_deep_pc", 32'(pc), 32'h5000);
    ret = 1'b1;
    tick();
    check("ras_pop1", 32'(pc), 32'h4002);
    tick();
    check("ras_pop2", 32'(pc), 32'h3002);
    tick();
    check("ras_pop3", 32'(pc), 32'h2002);
    tick();
    check("ras_pop4", 32'(pc), 32'h1002);
    check("ras_no_mis", 32'(misalign), 32'd0);
    tick();
    clear_ctl();
    check("ras_pop5", 32'(pc), 32'h0000);
    check("ras_underflow", 32'(misalign), 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Program-counter stage directly upstream of the datapath's W-bit adder.
- Drives the adder's operands: `pc_o` and `step_o`.
- Consumes the adder's sum (`seq_pc_i`) as the sequential next PC.
- Merges branch/jump redirects and halt/resume control, and presents the current PC to instruction fetch over a valid/ready handshake.

Parameters:
W, 16, datapath/PC width in bits
RESET_PC, 0, PC value loaded on reset (W bits)
STEP, 2, increment driven on step_o; must be a power of two
RAS_DEPTH, 4, return-address-stack entries (used only with PC_RAS_EN)

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  reset, asynchronous assert, active-low
seq_pc_i  input  W  adder sum y, equal to pc_o + step_o
pc_o  output  W  current PC, drives adder operand a and fetch address
step_o  output  W  constant STEP, drives adder operand b
fetch_valid_o  output  1  pc_o is a valid fetch request
fetch_ready_i  input  1  fetch accepts the request this cycle
br_taken_i  input  1  conditional branch resolved taken
br_target_i  input  W  branch target
jump_i  input  1  unconditional jump
jump_target_i  input  W  jump target
halt_i  input  1  request halt
resume_i  input  1  leave HALT
flush_o  output  1  one-cycle pulse on any accepted redirect
misalign_o  output  1  sticky: a redirect target had low bits set
call_i  input  1  (PC_RAS_EN only) jump is a call; push return address
ret_i  input  1  (PC_RAS_EN only) return; target comes from RAS

Behaviour:
- Reset (`rst_n` = 0, asynchronous) sets:
  - state = BOOT, `pc_o` = RESET_PC.
  - `fetch_valid_o` = 0, `flush_o` = 0, `misalign_o` = 0.
  - RAS empty.
- States:
  - BOOT: one cycle; then RUN unconditionally.
  - RUN: `fetch_valid_o` = 1.
  - HALT: `fetch_valid_o` = 0.
- Handshake:
  - fire = `fetch_valid_o` & `fetch_ready_i`.
  - While not fire, `pc_o` holds and `fetch_valid_o` stays high (no retraction).
- Next PC in RUN, priority order:
  - `jump_i` → `jump_target_i`.
  - else `br_taken_i` → `br_target_i`.
  - else fire → `seq_pc_i`.
  - else hold.
- Redirects:
  - Taken regardless of `fetch_ready_i`, with no added latency: the new PC appears on `pc_o` the cycle after the redirect input.
  - `flush_o` = 1 for exactly that next cycle.
- Target alignment:
  - Low log2(STEP) bits of any target are forced to 0.
  - If any of those bits were nonzero, `misalign_o` is set and stays set until reset.
- Wrap-around: arithmetic is modulo 2^W; no saturation or flag.
  - Example: `pc_o` = 0xFFFE with STEP = 2 → next PC 0x0000.
- `halt_i` in RUN:
  - Go to HALT the next cycle; `fetch_valid_o` drops the next cycle.
  - A redirect in the same cycle is still applied (PC updated, `flush_o` pulses).
  - Sequential advance happens only if fire occurred that cycle.
- HALT:
  - `pc_o` holds.
  - Redirects are ignored; `flush_o` = 0.
  - `resume_i` → RUN next cycle.
  - If `halt_i` and `resume_i` are both high, halt wins (stay in HALT).
- `step_o` is constant STEP, never gated.
- Mid-operation reset: immediate return to reset values; pending redirect discarded.

Optional Feature:
PC_RAS_EN
- Defined:
  - Adds the `call_i`/`ret_i` ports and a RAS_DEPTH-entry return-address stack.
  - `jump_i` & `call_i` pushes `seq_pc_i`.
  - `ret_i` (priority above `jump_i`) pops, and the popped value is the redirect target.
  - Push when full overwrites the oldest entry.
  - Pop when empty yields RESET_PC and sets `misalign_o`.
  - Simultaneous `call_i` & `ret_i`: `ret_i` wins, no push.
- Not defined: no `call_i`/`ret_i` ports, no RAS storage; behaviour exactly as above.

Decomposition:
- Package `pc_seq_pkg` holds:
  - State enum {BOOT, RUN, HALT}.
  - Next-PC select enum {HOLD, SEQ, BRANCH, JUMP, RET}.
  - Default RESET_PC and STEP constants.
- Sub-module `pc_ras`:
  - Circular stack with push/pop/full/empty.
  - Instantiated only under PC_RAS_EN.

Test Plan:
- Reset release, `fetch_ready_i` = 1, W = 16, STEP = 2 → BOOT 1 cycle, then `pc_o` = 0x0000, 0x0002, 0x0004 on consecutive cycles; `fetch_valid_o` = 1 from the 2nd cycle.
- `fetch_ready_i` = 0 for 3 cycles at `pc_o` = 0x0010 → `pc_o` holds 0x0010 with `fetch_valid_o` high; advances to 0x0012 the cycle after ready returns.
- `br_taken_i` = 1 with target 0x0100 and `jump_i` = 1 with target 0x0200 in the same cycle → `pc_o` = 0x0200 next cycle, `flush_o` pulses once; `br_target_i` 0x0101 later → `pc_o` = 0x0100, `misalign_o` = 1.
- `pc_o` = 0xFFFE, fire → `pc_o` = 0x0000, no flag.
- `halt_i` with jump to 0x0040 in the same cycle → `pc_o` = 0x0040, state HALT, `fetch_valid_o` = 0; further jumps ignored; `resume_i` → fetch resumes at 0x0040.
- PC_RAS_EN: call at 0x0020 to 0x0080, ret at 0x0084 → `pc_o` = 0x0022 after ret; 5 calls with depth 4 then 5 rets → first 4 pops correct, 5th yields RESET_PC and `misalign_o` = 1.
